// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//
// Bit-serial multi-bit subtract engine. Accepts an operand pair (a, b)
// through a valid/ready handshake, then walks the pair LSB first, one bit
// per clock, through two half-subtractor stages plus a borrow flip-flop.
// After WIDTH bits the result is presented to the consumer through a
// second valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    block can accept operands (high only in IDLE)
//   a           minuend, sampled on accept
//   b           subtrahend, sampled on accept
//   out_valid   result valid (high only in DONE)
//   out_ready   consumer accepts result
//   diff        (a - b) modulo 2^WIDTH
//   borrow_out  final borrow, 1 when a < b (unsigned)
//   zero        1 when diff == 0
//   busy        high while bits are being processed (RUN)

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d1;
    logic             br1;
    logic             d;
    logic             br2;
    logic [WIDTH-1:0] r_final;
    logic             last_bit;

    // Full-subtract cell for the current bit: first half-subtractor on the
    // operand bits, second on its difference and the stored borrow.
    // r_final is what r_sh becomes after this edge's shift, so on the last
    // bit it already holds the complete result.
    always_comb begin
        d1       = a_sh[0] ^ b_sh[0];
        br1      = ~a_sh[0] & b_sh[0];
        d        = d1 ^ br;
        br2      = ~d1 & br;
        r_final  = {d, r_sh[WIDTH-1:1]};
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status decode. Outputs are pure functions of
    // the state, so out_valid falls on the same edge that leaves DONE.
    // The spare encoding falls back to IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, bit counter, borrow flip-flop and the
    // registered result. The result registers only change on the last bit,
    // so they stay stable through DONE and keep their value in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_final;
                    br   <= br1 | br2;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff       <= r_final;
                        borrow_out <= br1 | br2;
                        zero       <= (r_final == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial controller that sequences a 1-bit half-subtractor datapath across a WIDTH-bit operand pair, LSB first, one bit per clock.
- Two half-subtractor stages plus a borrow flip-flop form the per-bit full-subtract cell; this block owns the FSM, bit counter, operand shift registers and result handshake.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready), as the multi-bit subtract engine built on the team's half-subtractor primitive.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend, sampled on accept
b  input  WIDTH  subtrahend, sampled on accept
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  final borrow; 1 when a < b (unsigned)
zero  output  1  1 when diff == 0
busy  output  1  high in RUN

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; diff=0, borrow_out=0, zero=0, out_valid=0, busy=0, in_ready=1 on the next cycle. Internal shift registers, counter and borrow FF are cleared. Reset applies from any state, including mid-RUN; the partial result is discarded and out_valid is never asserted for it.
- States: IDLE, RUN, DONE; the FSM is fully encoded, and unused encodings go to IDLE.
- IDLE: in_ready=1. When in_valid=1 at edge k: load a_sh<=a, b_sh<=b, borrow FF<=0, cnt<=0, go to RUN.
- RUN: busy=1, in_ready=0. At each edge:
  - Stage 1: d1=a_sh[0]^b_sh[0], br1=~a_sh[0]&b_sh[0].
  - Stage 2: d=d1^br, br2=~d1&br.
  - br<=br1|br2. d shifts into MSB of result shift register r_sh (right shift). a_sh and b_sh shift right. cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, the last bit is processed and the FSM goes to DONE. On that same edge: diff<=final r_sh value including the last bit, borrow_out<=br1|br2, zero<=(final diff==0).
  - Bit i is processed at edge k+1+i. out_valid is high after edge k+WIDTH, which gives latency WIDTH cycles from accept to out_valid.
- DONE: out_valid=1. diff, borrow_out and zero are held stable while out_ready=0. When out_ready=1 at an edge: go to IDLE, out_valid<=0. diff, borrow_out and zero retain their values until the next DONE entry. There is no accept in DONE; minimum issue interval is WIDTH+2 cycles.
- in_valid in RUN or DONE is ignored; a and b are not sampled. The producer must hold its data until in_ready.
- out_ready outside DONE is ignored.
- Arithmetic: diff == (a - b) mod 2^WIDTH. borrow_out == (a < b) unsigned.
- cnt width is clog2(WIDTH); it must reach WIDTH-1 without overflow.

Test Plan:
- WIDTH=8, a=8'd5, b=8'd3, out_ready=1 -> out_valid after 8 cycles from accept; diff=8'h02, borrow_out=0, zero=0; in_ready back to 1 the cycle after handshake.
- a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1, zero=0. a=8'h00, b=8'hFF -> diff=8'h01, borrow_out=1 (full borrow ripple).
- a=8'hAA, b=8'hAA -> diff=8'h00, borrow_out=0, zero=1.
- Backpressure: a=8'h80, b=8'h01, out_ready=0 for 5 cycles after out_valid, then 1 -> diff=8'h7F held stable throughout; out_valid drops exactly one edge after out_ready=1.
- Accept a=8'h10, b=8'h01; pulse in_valid with a=8'hFF, b=8'hFF at cycle 3 of RUN -> ignored, result diff=8'h0F. Then rst_n=0 for one edge at cycle 4 of a new op -> IDLE, out_valid never asserts, all outputs 0.
- Random: 200 operand pairs with random out_ready and in_valid gaps -> every result matches (a-b) mod 256 and a<b; exactly one out_valid handshake per accept.
